// File: rtl/xor_req_arbiter.sv
// rtl/xor_req_arbiter.sv - round-robin arbiter sharing one XOR unit among N_REQ requesters
// Define XOR_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module xor_req_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] req_en,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0] req_rdy,
  output logic             dut_a_data,
  output logic             dut_a_en,
  input  logic             dut_a_rdy,
  output logic             dut_b_data,
  output logic             dut_b_en,
  input  logic             dut_b_rdy,
  input  logic             dut_y_data,
  input  logic             dut_y_en,
  output logic             dut_y_rdy,
  output logic             rsp_data,
  output logic [ID_W-1:0]  rsp_id,
  output logic             rsp_en,
  input  logic             rsp_rdy,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] win_id;
  logic            win_vld;
  logic            op_a, op_b;
  logic            a_done, b_done;
  logic            y_q;
  logic            req_hs, a_hs, b_hs, y_hs, r_hs;

`ifdef XOR_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest pending index is the last (winning) assignment.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_en[i]) begin
        win_id  = ID_W'(i);
        win_vld = 1'b1;
      end
    end
  end
`else
  logic [ID_W-1:0] last_grant;
  int              rr_idx;

  // Scan offsets from far to near so the requester closest after last_grant wins.
  always_comb begin
    win_id  = '0;
    win_vld = 1'b0;
    rr_idx  = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      rr_idx = (int'(last_grant) + i) % N_REQ;
      if (req_en[rr_idx]) begin
        win_id  = ID_W'(rr_idx);
        win_vld = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    req_rdy    = '0;
    dut_a_en   = 1'b0;
    dut_b_en   = 1'b0;
    dut_y_rdy  = 1'b0;
    rsp_en     = 1'b0;
    busy       = (state_q != IDLE);
    dut_a_data = op_a;
    dut_b_data = op_b;
    rsp_data   = y_q;
    rsp_id     = cur_id;
    case (state_q)
      IDLE:  if (RST_N && win_vld) req_rdy[win_id] = 1'b1;
      ISSUE: begin
        dut_a_en = !a_done;
        dut_b_en = !b_done;
      end
      WAIT:  dut_y_rdy = 1'b1;
      RESP:  rsp_en = 1'b1;
      default: state_d = IDLE;
    endcase
    req_hs = |(req_rdy & req_en);
    a_hs   = dut_a_en && dut_a_rdy;
    b_hs   = dut_b_en && dut_b_rdy;
    y_hs   = dut_y_rdy && dut_y_en;
    r_hs   = rsp_en && rsp_rdy;
    case (state_q)
      IDLE:    if (req_hs) state_d = ISSUE;
      ISSUE:   if ((a_done || a_hs) && (b_done || b_hs)) state_d = WAIT;
      WAIT:    if (y_hs) state_d = RESP;
      RESP:    if (r_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_a       <= 1'b0;
      op_b       <= 1'b0;
      cur_id     <= '0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      y_q        <= 1'b0;
`ifndef XOR_ARB_FIXED_PRIO_EN
      last_grant <= ID_W'(N_REQ - 1);
`endif
    end else begin
      if (req_hs) begin
        op_a   <= req_a[win_id];
        op_b   <= req_b[win_id];
        cur_id <= win_id;
        a_done <= 1'b0;
        b_done <= 1'b0;
      end
      if (a_hs) a_done <= 1'b1;
      if (b_hs) b_done <= 1'b1;
      if (y_hs) y_q <= dut_y_data;
`ifndef XOR_ARB_FIXED_PRIO_EN
      if (r_hs) last_grant <= cur_id;
`endif
    end
  end

endmodule
